shift8_deser: RTL
=================

// Module: shift8_deser
// PURPOSE
//   Serial-to-parallel receiver; the receiving end of the 8-bit shifter datapath.
//   Accepts one bit per s_valid strobe and assembles WIDTH bits into a word.
//   Each word is presented in an output holding register with a valid/ready handshake.
//   Flags overrun when a finished word cannot be delivered.
// PARAMETERS
//   WIDTH      8   bits per word (>=2)
//   MSB_FIRST  1   1: first received bit lands in q[WIDTH-1]; 0: first bit lands in q[0]
// PORTS
//   clk        in   1      single clock, rising edge
//   reset_n    in   1      asynchronous, active-low reset
//   s_in       in   1      serial data bit
//   s_valid    in   1      s_in is valid this cycle
//   start      in   1      frame sync: discard partial word, restart at bit 0
//   q          out  WIDTH  assembled word (holding register)
//   q_valid    out  1      q holds an undelivered word
//   q_ready    in   1      consumer accepts q this cycle when q_valid=1
//   overrun    out  1      sticky: a completed word was dropped
//   clr_ovr    in   1      clears overrun
//   bit_cnt    out  $clog2(WIDTH)  bits received in the current partial word
// BEHAVIOUR
//   Reset (async, reset_n=0): shift reg, q, bit_cnt = 0; q_valid = 0; overrun = 0; FSM = RX_IDLE.
//   FSM states:
//     RX_IDLE   bit_cnt==0, no partial word.
//     RX_SHIFT  1..WIDTH-1 bits held.
//   Transitions:
//     RX_IDLE->RX_SHIFT on s_valid.
//     RX_SHIFT->RX_IDLE on the WIDTH-th bit, or on start without s_valid.
//   Shifting:
//     MSB_FIRST=1: sr <= {sr[WIDTH-2:0], s_in}.
//     MSB_FIRST=0: sr <= {s_in, sr[WIDTH-1:1]}.
//   Completion: s_valid=1 with bit_cnt==WIDTH-1.
//     The completed word {sr, s_in} (shifted form) goes straight to q at that same edge.
//     q_valid=1 after that edge; latency is 0 cycles after the last bit's edge.
//     bit_cnt wraps to 0.
//   Handshake:
//     Word delivered on any edge where q_valid & q_ready; q_valid then falls.
//     q stays stable while q_valid=1 and not delivered.
//   Simultaneous events:
//     completion & q_valid & q_ready: new word replaces q, q_valid stays 1, no overrun.
//     completion & q_valid & !q_ready: new word dropped, q unchanged, overrun <= 1.
//     completion & clr_ovr & overrun condition: set wins, overrun = 1.
//     start & s_valid: partial discarded, s_in taken as bit 0 (bit_cnt -> 1).
//     start & !s_valid: partial discarded, bit_cnt -> 0, RX_IDLE.
//     start never affects q, q_valid or overrun.
//     s_valid=0: no state change except handshake and clr_ovr.
//   Reset mid-word: partial bits and any pending q are lost; no output glitch beyond async clear.
// STRUCTURE
//   Shared package:
//     RX_IDLE/RX_SHIFT state encodings (1-bit).
//     Default WIDTH constant shared with the shifter transmitter.
//   One sub-module: shift8_hold_reg, a WIDTH-bit register with load enable and async active-low
//     clear, built from the team's reset flip-flops; used for q.
//   Shift register, counter, FSM and flags stay in the top module.
// TESTING
//   MSB_FIRST=1, bits 1,0,1,0,0,1,0,1 on consecutive s_valid cycles, q_ready=1
//     -> q=8'hA5, q_valid=1 for 1 cycle, overrun=0.
//   MSB_FIRST=0, same bit stream -> q=8'hA5 (bit-reversed stream, palindrome check);
//     repeat with 8'h01 MSB-first stream -> q=8'h80.
//   q_ready=0, two full words 8'h3C then 8'hC3 -> q stays 8'h3C, overrun=1;
//     then clr_ovr=1 for one cycle -> overrun=0, q still 8'h3C.
//   4 bits, then start with s_valid=0, then 8 bits of 8'h5A -> q=8'h5A, bit_cnt 4->0.
//   start & s_valid on the same cycle -> bit_cnt=1.
//   reset_n low for 1 cycle with bit_cnt=5 and q_valid=1 -> all outputs 0 immediately;
//     next 8 bits yield a clean word.
//   Back-to-back words with q_ready pulsed on each completion cycle
//     -> q updates every 8 s_valid cycles, q_valid stays 1, overrun stays 0.

Source files
------------

// File: rtl/shift8_deser_pkg.sv
// Shared definitions for the 8-bit shifter datapath: receiver FSM encodings and default word width.
package shift8_deser_pkg;

   localparam int SHIFT8_WIDTH = 8;

   typedef enum logic {
      RX_IDLE  = 1'b0,
      RX_SHIFT = 1'b1
   } rxState_e;

endpackage

// File: rtl/shift8_hold_reg.sv
// WIDTH-bit holding register with load enable and asynchronous active-low clear.
module shift8_hold_reg #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             load_i,
   input  logic [WIDTH-1:0] d_i,
   output logic [WIDTH-1:0] q_o
);

   logic [WIDTH-1:0] data_q;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         data_q <= '0;
      end else if (load_i) begin
         data_q <= d_i;
      end
   end

   assign q_o = data_q;

endmodule

// File: rtl/shift8_deser.sv
// Serial-to-parallel receiver: assembles WIDTH bits into a word and offers it through a
// valid/ready holding register, flagging overrun when a finished word cannot be delivered.
module shift8_deser
   import shift8_deser_pkg::*;
#(
   parameter int WIDTH     = SHIFT8_WIDTH,
   parameter int MSB_FIRST = 1
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic                     s_in,
   input  logic                     s_valid,
   input  logic                     start,
   output logic [WIDTH-1:0]         q,
   output logic                     q_valid,
   input  logic                     q_ready,
   output logic                     overrun,
   input  logic                     clr_ovr,
   output logic [$clog2(WIDTH)-1:0] bit_cnt
);

   localparam int            CW       = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

   rxState_e         state_q;
   logic [WIDTH-1:0] sr_q;
   logic [WIDTH-1:0] srBase;
   logic [WIDTH-1:0] shifted;
   logic [CW-1:0]    bitCnt_q;
   logic             qValid_q, qValid_d;
   logic             overrun_q, overrun_d;
   logic             complete, deliver, loadQ, dropWord;

   // A frame sync or an empty receiver shifts from zero, so the new bit becomes bit 0.
   always_comb begin
      srBase = (start || state_q == RX_IDLE) ? '0 : sr_q;
      if (MSB_FIRST != 0) begin
         shifted = {srBase[WIDTH-2:0], s_in};
      end else begin
         shifted = {s_in, srBase[WIDTH-1:1]};
      end
   end

   assign complete = s_valid && !start && (state_q == RX_SHIFT) && (bitCnt_q == LAST_BIT);
   assign deliver  = qValid_q && q_ready;
   assign loadQ    = complete && (!qValid_q || q_ready);
   assign dropWord = complete && qValid_q && !q_ready;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= RX_IDLE;
         sr_q     <= '0;
         bitCnt_q <= '0;
      end else if (s_valid) begin
         if (complete) begin
            state_q  <= RX_IDLE;
            sr_q     <= '0;
            bitCnt_q <= '0;
         end else begin
            state_q  <= RX_SHIFT;
            sr_q     <= shifted;
            bitCnt_q <= start ? CW'(1) : bitCnt_q + 1'b1;
         end
      end else if (start) begin
         state_q  <= RX_IDLE;
         sr_q     <= '0;
         bitCnt_q <= '0;
      end
   end

   // Setting overrun takes priority over a simultaneous clear.
   always_comb begin
      qValid_d = qValid_q;
      if (loadQ) begin
         qValid_d = 1'b1;
      end else if (deliver) begin
         qValid_d = 1'b0;
      end
      overrun_d = overrun_q;
      if (dropWord) begin
         overrun_d = 1'b1;
      end else if (clr_ovr) begin
         overrun_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         qValid_q  <= 1'b0;
         overrun_q <= 1'b0;
      end else begin
         qValid_q  <= qValid_d;
         overrun_q <= overrun_d;
      end
   end

   shift8_hold_reg #(
      .WIDTH (WIDTH)
   ) uHoldReg (
      .clk     (clk),
      .reset_n (reset_n),
      .load_i  (loadQ),
      .d_i     (shifted),
      .q_o     (q)
   );

   assign q_valid = qValid_q;
   assign overrun = overrun_q;
   assign bit_cnt = bitCnt_q;

endmodule
